// File: rtl/ram_word_sequencer.sv
// Load/store engine between an 8 x 32-bit registered-read RAM and a 256-bit operand port.
// Optional build macro STORE_VERIFY_EN adds a read-back compare pass after every store.
module ram_word_sequencer #(
  parameter int WORDS = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                store_start,
  input  logic [WORDS*DW-1:0] store_data,
  output logic [WORDS*DW-1:0] load_data,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_wdata,
  output logic                ram_we,
  input  logic [DW-1:0]       ram_rdata,
  output logic                verify_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOAD_TAIL, S_STORE, S_VERIFY, S_VERIFY_TAIL, S_DONE
  } state_t;

  state_t              r_state, w_state_next;
  logic [AW-1:0]       r_cnt, w_cnt_next;
  logic [WORDS*DW-1:0] r_load_data;
  logic [WORDS*DW-1:0] r_store_data;
  logic [DW-1:0]       w_store_word [WORDS];
  logic                w_last;
  logic                w_ld_cap;
  logic [AW-1:0]       w_rd_idx;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
    assign w_store_word[gi] = r_store_data[gi*DW +: DW];
  end

  assign w_last    = (r_cnt == AW'(WORDS-1));
  // Read data lags the address by one cycle, so the word landing now is cnt-1 (or 7 in a tail state).
  assign w_rd_idx  = (r_state == S_LOAD_TAIL || r_state == S_VERIFY_TAIL) ? AW'(WORDS-1) : r_cnt - 1'b1;
  assign w_ld_cap  = (r_state == S_LOAD && r_cnt != '0) || (r_state == S_LOAD_TAIL);
  assign load_data = r_load_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_next = S_LOAD;
          w_cnt_next   = '0;
        end else if (store_start) begin
          w_state_next = S_STORE;
          w_cnt_next   = '0;
        end
      end
      S_LOAD: begin
        if (w_last) w_state_next = S_LOAD_TAIL;
        else        w_cnt_next   = r_cnt + 1'b1;
      end
      S_LOAD_TAIL: w_state_next = S_DONE;
      S_STORE: begin
        if (w_last) begin
`ifdef STORE_VERIFY_EN
          w_state_next = S_VERIFY;
          w_cnt_next   = '0;
`else
          w_state_next = S_DONE;
`endif
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
`ifdef STORE_VERIFY_EN
      S_VERIFY: begin
        if (w_last) w_state_next = S_VERIFY_TAIL;
        else        w_cnt_next   = r_cnt + 1'b1;
      end
      S_VERIFY_TAIL: w_state_next = S_DONE;
`endif
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (r_state)
      S_LOAD, S_VERIFY:           ram_addr = r_cnt;
      S_LOAD_TAIL, S_VERIFY_TAIL: ram_addr = AW'(WORDS-1);
      S_STORE: begin
        ram_we    = 1'b1;
        ram_addr  = r_cnt;
        ram_wdata = w_store_word[r_cnt];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_load_data  <= '0;
      r_store_data <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (r_state == S_IDLE && store_start && !load_start)
        r_store_data <= store_data;
      if (w_ld_cap)
        r_load_data[w_rd_idx*DW +: DW] <= ram_rdata;
    end
  end

`ifdef STORE_VERIFY_EN
  logic r_verify_err;
  logic w_vf_cap;
  logic w_accept;

  assign w_vf_cap   = (r_state == S_VERIFY && r_cnt != '0) || (r_state == S_VERIFY_TAIL);
  assign w_accept   = (r_state == S_IDLE) && (load_start || store_start);
  assign verify_err = r_verify_err;

  // Sticky across the whole verify pass; only a newly accepted operation clears it.
  always_ff @(posedge clk) begin
    if (rst)
      r_verify_err <= 1'b0;
    else if (w_accept)
      r_verify_err <= 1'b0;
    else if (w_vf_cap && ram_rdata != w_store_word[w_rd_idx])
      r_verify_err <= 1'b1;
  end
`else
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_word_sequencer.sv
// Randomized bench for ram_word_sequencer: a behavioural RAM plus a word-level reference model.
`timescale 1ns/1ps
module tb_ram_word_sequencer;
  localparam int LOAD_DONE = 10;
`ifdef STORE_VERIFY_EN
  localparam int STORE_DONE = 18;
`else
  localparam int STORE_DONE = 9;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_start = 1'b0;
  logic         store_start = 1'b0;
  logic [255:0] store_data = '0;
  logic [255:0] load_data;
  logic         busy, done, ram_we, verify_err;
  logic [2:0]   ram_addr;
  logic [31:0]  ram_wdata;
  logic [31:0]  ram_rdata;

  logic [31:0]  mem [8];
  logic [31:0]  ref_mem [8];
  logic [255:0] ref_load = '0;
  logic [255:0] golden = 256'h4fe342e2_fe1a7f9b_8ee7eb4a_7c0f9e16_2bce3357_6b315ece_cbb64068_37bf51f5;
  bit           do_preload = 1'b1;
  bit           corrupt = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           op_id = 0;

  always #5 clk = ~clk;

  ram_word_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .store_start(store_start),
    .store_data (store_data),
    .load_data  (load_data),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .verify_err (verify_err)
  );

  // Behavioural RAM with one-cycle registered read; corrupt flips a bit of word 5 on read.
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= ref_mem[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr] ^ ((corrupt && ram_addr == 3'd5) ? 32'h0000_0100 : 32'h0);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack8(input logic [31:0] a [8]);
    logic [255:0] v = '0;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = a[i];
    return v;
  endfunction

  // One operation starting in the current (IDLE) cycle, with random start noise while busy.
  task automatic do_op(input bit want_load, input bit want_store, input logic [255:0] d);
    bit   is_load  = want_load;
    int   exp_done = is_load ? LOAD_DONE : STORE_DONE;
    int   done_cyc = -1;
    int   done_cnt = 0;
    int   we_cnt   = 0;
    int   bad_we   = 0;
    int   busy_bad = 0;
    logic exp_verr = 1'b0;
    load_start  = want_load;
    store_start = want_store;
    store_data  = d;
    for (int c = 1; c <= exp_done + 4; c++) begin
      @(posedge clk); #1;
      if (ram_we) begin
        if (is_load || we_cnt >= 8 || ram_addr !== 3'(we_cnt) ||
            ram_wdata !== d[32*we_cnt +: 32] || c != we_cnt + 1) bad_we++;
        we_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy !== (c <= exp_done)) busy_bad++;
      if (c <= exp_done) begin
        load_start  = ($urandom_range(0, 3) == 0);
        store_start = ($urandom_range(0, 3) == 0);
        store_data  = {8{$urandom}};
      end else begin
        load_start  = 1'b0;
        store_start = 1'b0;
      end
    end
    if (is_load) begin
      ref_load = pack8(ref_mem);
    end else begin
      for (int i = 0; i < 8; i++) ref_mem[i] = d[32*i +: 32];
`ifdef STORE_VERIFY_EN
      exp_verr = corrupt;
`endif
    end
    op_id++;
    $display("op %0d %s data=%h done_cycle=%0d writes=%0d", op_id, is_load ? "load " : "store",
             is_load ? load_data : d, done_cyc, we_cnt);
    check("done_cycle", done_cyc, exp_done);
    check("done_count", done_cnt, 1);
    check("we_count", we_cnt, is_load ? 0 : 8);
    check("we_order", bad_we, 0);
    check("busy_window", busy_bad, 0);
    check("load_data", load_data, ref_load);
    check("verify_err", verify_err, exp_verr);
    if (!is_load) check("ram_contents", pack8(mem), pack8(ref_mem));
  endtask

  task automatic reset_mid_store(input logic [255:0] d);
    int done_cnt = 0;
    store_start = 1'b1;
    store_data  = d;
    @(posedge clk); #1;
    store_start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_we", ram_we, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_addr", ram_addr, 0);
    check("rst_mid_wdata", ram_wdata, 0);
    check("rst_mid_load_data", load_data, 0);
    check("rst_mid_verify_err", verify_err, 0);
    for (int i = 0; i < 4; i++) ref_mem[i] = d[32*i +: 32];
    ref_load = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || ram_we) done_cnt++;
    end
    op_id++;
    $display("op %0d store aborted by reset data=%h", op_id, d);
    check("rst_mid_no_activity", done_cnt, 0);
    check("rst_mid_ram", pack8(mem), pack8(ref_mem));
  endtask

  initial begin
    int kind;
    for (int i = 0; i < 8; i++) ref_mem[i] = golden[32*i +: 32];
    repeat (3) begin @(posedge clk); #1; end
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_we", ram_we, 0);
    check("reset_addr", ram_addr, 0);
    check("reset_wdata", ram_wdata, 0);
    check("reset_load_data", load_data, 0);
    check("reset_verify_err", verify_err, 0);
    rst = 1'b0;
    do_preload = 1'b0;
    @(posedge clk); #1;

    do_op(1'b1, 1'b0, '0);
    check("golden_load", load_data, golden);
    do_op(1'b0, 1'b1, {4{64'h0123456789abcdef}});
    do_op(1'b1, 1'b0, '0);
    do_op(1'b1, 1'b1, {8{$urandom}});
    reset_mid_store({8{$urandom}});
    do_op(1'b1, 1'b0, '0);
`ifdef STORE_VERIFY_EN
    corrupt = 1'b1;
    do_op(1'b0, 1'b1, {8{$urandom}});
    corrupt = 1'b0;
    do_op(1'b0, 1'b1, {8{$urandom}});
`endif
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 2);
      do_op(kind != 1, kind != 0, {8{$urandom}});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
